auto_player: RTL and testbench

Parametrised autoplay sequencer for the buzzer path. It plays a selectable song from a multi-song ROM, supports per-note durations in beats, inter-note gaps, pause/resume, stop, loop or one-shot playback, and restart on new selection. It sits between the mode/switch front end and the buzzer tone generator, which consumes `note_out` as a note code.

---
 rtl/player_pkg.sv | 24 ++
 rtl/song_rom.sv | 58 +++++
 rtl/auto_player.sv | 151 +++++++++++++++
 tb/tb_auto_player.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/player_pkg.sv
// Shared types and constants for the autoplay sequencer and its song ROM.
package player_pkg;

   localparam int ENTRY_NOTE_W = 4;
   localparam int SONG_CNT     = 4;

   localparam logic [ENTRY_NOTE_W-1:0] NOTE_REST = '0;

   // Number of notes in each ROM song, valid range 1..MAX_LEN.
   localparam int unsigned SONG_LEN [SONG_CNT] = '{3, 1, 4, 2};

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      PLAY,
      GAP
   } player_state_t;

   typedef struct packed {
      logic [ENTRY_NOTE_W-1:0] note;
      logic [1:0]              beats;
   } note_entry_t;

endpackage

// File: rtl/song_rom.sv
// Multi-song note ROM; synchronous read, one cycle latency, address {song, pos}.
module song_rom
   import player_pkg::*;
#(
   parameter int NUM_SONGS = 4,
   parameter int MAX_LEN   = 32,
   parameter int NOTE_W    = 4,
   localparam int SONG_W   = $clog2(NUM_SONGS),
   localparam int POS_W    = $clog2(MAX_LEN),
   localparam int ADDR_W   = SONG_W + POS_W
)(
   input  logic              clk,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] addr,
   output note_entry_t       rd_data
);

   function automatic logic [NOTE_W+1:0] ent(input int note, input int beats);
      return {NOTE_W'(note), 2'(beats)};
   endfunction

   // Unlisted positions read as a one-beat rest.
   function automatic logic [NOTE_W+1:0] rom_word(input logic [ADDR_W-1:0] a);
      logic [NOTE_W+1:0] w;
      w = ent(0, 0);
      case (int'(a[ADDR_W-1:POS_W]))
         0: case (int'(a[POS_W-1:0]))
               0: w = ent(1, 0);
               1: w = ent(2, 1);
               2: w = ent(3, 0);
               default: ;
            endcase
         1: case (int'(a[POS_W-1:0]))
               0: w = ent(5, 3);
               default: ;
            endcase
         2: case (int'(a[POS_W-1:0]))
               0: w = ent(8, 1);
               1: w = ent(6, 0);
               2: w = ent(4, 0);
               3: w = ent(10, 2);
               default: ;
            endcase
         3: case (int'(a[POS_W-1:0]))
               0: w = ent(12, 1);
               1: w = ent(9, 3);
               default: ;
            endcase
         default: ;
      endcase
      return w;
   endfunction

   always_ff @(posedge clk) begin
      if (rd_en) rd_data <= note_entry_t'(rom_word(addr));
   end

endmodule

// File: rtl/auto_player.sv
// Autoplay sequencer: walks a ROM song note by note, feeding note codes to the buzzer.
module auto_player
   import player_pkg::*;
#(
   parameter int NOTE_W         = 4,
   parameter int NUM_SONGS      = 4,
   parameter int SEL_W          = 2,
   parameter int MAX_LEN        = 32,
   parameter int POS_W          = 5,
   parameter int TICKS_PER_BEAT = 500000,
   parameter int GAP_TICKS      = 5000
)(
   input  logic              clk,
   input  logic              rst,
   input  logic [SEL_W-1:0]  song_select,
   input  logic              start,
   input  logic              stop,
   input  logic              pause,
   input  logic              loop_en,
   output logic [NOTE_W-1:0] note_out,
   output logic              busy,
   output logic              done,
   output logic [POS_W-1:0]  position
);

   localparam int CNT_W = $clog2(4 * TICKS_PER_BEAT);
   localparam logic [CNT_W-1:0] GAP_END = CNT_W'(GAP_TICKS - 1);

   // Last PLAY tick for a note; the gap is carved out of the note's own duration.
   function automatic logic [CNT_W-1:0] play_limit(input logic [1:0] beats);
      logic [CNT_W-1:0] lim;
      case (beats)
         2'd0:    lim = CNT_W'(1 * TICKS_PER_BEAT - GAP_TICKS - 1);
         2'd1:    lim = CNT_W'(2 * TICKS_PER_BEAT - GAP_TICKS - 1);
         2'd2:    lim = CNT_W'(3 * TICKS_PER_BEAT - GAP_TICKS - 1);
         default: lim = CNT_W'(4 * TICKS_PER_BEAT - GAP_TICKS - 1);
      endcase
      return lim;
   endfunction

   player_state_t     state;
   logic [SEL_W-1:0]  song_q;
   logic [NOTE_W-1:0] note_q;
   logic [1:0]        beats_q;
   logic [CNT_W-1:0]  tick;
   logic              load_q;
   logic              load_fire;
   logic [POS_W-1:0]  last_pos;
   note_entry_t       rom_data;

   song_rom #(
      .NUM_SONGS (NUM_SONGS),
      .MAX_LEN   (MAX_LEN),
      .NOTE_W    (NOTE_W)
   ) u_rom (
      .clk     (clk),
      .rd_en   (state == FETCH),
      .addr    ({song_q, position}),
      .rd_data (rom_data)
   );

   assign last_pos  = POS_W'(SONG_LEN[song_q] - 1);
   assign load_fire = (state == PLAY) && load_q && !stop && !start && !pause;

   always_ff @(posedge clk) begin
      if (load_fire) begin
         note_q  <= rom_data.note;
         beats_q <= rom_data.beats;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         song_q   <= '0;
         position <= '0;
         tick     <= '0;
         load_q   <= 1'b0;
         note_out <= NOTE_REST;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         done <= 1'b0;
         if (stop) begin
            state    <= IDLE;
            position <= '0;
            tick     <= '0;
            load_q   <= 1'b0;
            note_out <= NOTE_REST;
            busy     <= 1'b0;
         end else if (start) begin
            song_q   <= song_select;
            state    <= FETCH;
            position <= '0;
            tick     <= '0;
            load_q   <= 1'b0;
            note_out <= NOTE_REST;
            busy     <= 1'b1;
         end else if (pause && state != IDLE) begin
            note_out <= NOTE_REST;
         end else begin
            case (state)
               IDLE: ;
               FETCH: begin
                  state  <= PLAY;
                  load_q <= 1'b1;
                  tick   <= '0;
               end
               PLAY: begin
                  // First PLAY cycle takes the ROM word, so the note sounds one cycle later.
                  if (load_q) begin
                     load_q   <= 1'b0;
                     tick     <= '0;
                     note_out <= rom_data.note;
                  end else if (tick == play_limit(beats_q)) begin
                     state    <= GAP;
                     tick     <= '0;
                     note_out <= NOTE_REST;
                  end else begin
                     tick     <= tick + 1'b1;
                     note_out <= note_q;
                  end
               end
               GAP: begin
                  note_out <= NOTE_REST;
                  if (tick == GAP_END) begin
                     tick <= '0;
                     if (position == last_pos) begin
                        position <= '0;
                        if (loop_en) begin
                           state <= FETCH;
                        end else begin
                           state <= IDLE;
                           busy  <= 1'b0;
                           done  <= 1'b1;
                        end
                     end else begin
                        position <= position + 1'b1;
                        state    <= FETCH;
                     end
                  end else begin
                     tick <= tick + 1'b1;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_auto_player.sv
// Directed bench for auto_player with short beats (4 ticks/beat, 1-tick gap).
module tb_auto_player;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [1:0] song_select = '0;
   logic       start = 1'b0;
   logic       stop = 1'b0;
   logic       pause = 1'b0;
   logic       loop_en = 1'b0;
   logic [3:0] note_out;
   logic       busy;
   logic       done;
   logic [4:0] position;

   int vectors = 0;
   int miscompares = 0;

   auto_player #(
      .NOTE_W         (4),
      .NUM_SONGS      (4),
      .SEL_W          (2),
      .MAX_LEN        (32),
      .POS_W          (5),
      .TICKS_PER_BEAT (4),
      .GAP_TICKS      (1)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .song_select (song_select),
      .start       (start),
      .stop        (stop),
      .pause       (pause),
      .loop_en     (loop_en),
      .note_out    (note_out),
      .busy        (busy),
      .done        (done),
      .position    (position)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      vectors++;
      if ({note_out, busy, done, position} !== 11'd0) begin
         miscompares++;
         $display("FAIL reset: note/busy/done/pos got %0d/%0b/%0b/%0d want 0/0/0/0", note_out, busy, done, position);
      end
      pause = 1'b1;
      step();
      pause = 1'b0;
      step();
      vectors++;
      if ({note_out, busy, done, position} !== 11'd0) begin
         miscompares++;
         $display("FAIL idle_pause: note/busy/done/pos got %0d/%0b/%0b/%0d want 0/0/0/0", note_out, busy, done, position);
      end
   endtask

   task automatic test_one_shot();
      int exp_note [24] = '{0,0,1,1,1,0,0,0,2,2,2,2,2,2,2,0,0,0,3,3,3,0,0,0};
      int exp_pos  [24] = '{0,0,0,0,0,0,1,1,1,1,1,1,1,1,1,1,2,2,2,2,2,2,0,0};
      logic [10:0] want;
      song_select = 2'd0;
      loop_en = 1'b0;
      start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < 24; i++) begin
         if (i > 0) step();
         want = {4'(exp_note[i]), (i < 22), (i == 22), 5'(exp_pos[i])};
         vectors++;
         if ({note_out, busy, done, position} !== want) begin
            miscompares++;
            $display("FAIL one_shot cyc N+%0d: note/busy/done/pos got %0d/%0b/%0b/%0d want %0d/%0b/%0b/%0d",
                     i + 1, note_out, busy, done, position, exp_note[i], i < 22, i == 22, exp_pos[i]);
         end
      end
   endtask

   task automatic test_loop();
      int exp_note [26] = '{0,0,1,1,1,0,0,0,2,2,2,2,2,2,2,0,0,0,3,3,3,0,0,0,1,1};
      int exp_pos  [26] = '{0,0,0,0,0,0,1,1,1,1,1,1,1,1,1,1,2,2,2,2,2,2,0,0,0,0};
      logic [10:0] want;
      song_select = 2'd0;
      loop_en = 1'b1;
      start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < 26; i++) begin
         if (i > 0) step();
         want = {4'(exp_note[i]), 1'b1, 1'b0, 5'(exp_pos[i])};
         vectors++;
         if ({note_out, busy, done, position} !== want) begin
            miscompares++;
            $display("FAIL loop cyc N+%0d: note/busy/done/pos got %0d/%0b/%0b/%0d want %0d/1/0/%0d",
                     i + 1, note_out, busy, done, position, exp_note[i], exp_pos[i]);
         end
      end
      stop = 1'b1;
      step();
      stop = 1'b0;
      loop_en = 1'b0;
      vectors++;
      if ({note_out, busy, done, position} !== 11'd0) begin
         miscompares++;
         $display("FAIL loop_stop: note/busy/done/pos got %0d/%0b/%0b/%0d want 0/0/0/0", note_out, busy, done, position);
      end
   endtask

   task automatic test_pause();
      song_select = 2'd0;
      start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 1; i < 11; i++) step();
      vectors++;
      if ({note_out, position} !== {4'd2, 5'd1}) begin
         miscompares++;
         $display("FAIL pause_pre: note/pos got %0d/%0d want 2/1", note_out, position);
      end
      pause = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step();
         vectors++;
         if ({note_out, busy, done, position} !== {4'd0, 1'b1, 1'b0, 5'd1}) begin
            miscompares++;
            $display("FAIL pause_hold %0d: note/busy/done/pos got %0d/%0b/%0b/%0d want 0/1/0/1", i, note_out, busy, done, position);
         end
      end
      pause = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         vectors++;
         if ({note_out, position} !== {4'd2, 5'd1}) begin
            miscompares++;
            $display("FAIL pause_resume %0d: note/pos got %0d/%0d want 2/1", i, note_out, position);
         end
      end
      step();
      vectors++;
      if ({note_out, position} !== {4'd0, 5'd1}) begin
         miscompares++;
         $display("FAIL pause_gap: note/pos got %0d/%0d want 0/1", note_out, position);
      end
      step();
      vectors++;
      if ({note_out, position} !== {4'd0, 5'd2}) begin
         miscompares++;
         $display("FAIL pause_next: note/pos got %0d/%0d want 0/2", note_out, position);
      end
      stop = 1'b1;
      step();
      stop = 1'b0;
   endtask

   task automatic test_select();
      song_select = 2'd0;
      start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 1; i < 5; i++) step();
      song_select = 2'd1;
      for (int i = 5; i < 10; i++) step();
      vectors++;
      if ({note_out, position} !== {4'd2, 5'd1}) begin
         miscompares++;
         $display("FAIL select_ignored: note/pos got %0d/%0d want 2/1", note_out, position);
      end
      start = 1'b1;
      step();
      start = 1'b0;
      vectors++;
      if ({note_out, busy, position} !== {4'd0, 1'b1, 5'd0}) begin
         miscompares++;
         $display("FAIL restart: note/busy/pos got %0d/%0b/%0d want 0/1/0", note_out, busy, position);
      end
      step();
      for (int i = 0; i < 15; i++) begin
         step();
         vectors++;
         if ({note_out, busy, done, position} !== {4'd5, 1'b1, 1'b0, 5'd0}) begin
            miscompares++;
            $display("FAIL song1_note %0d: note/busy/done/pos got %0d/%0b/%0b/%0d want 5/1/0/0", i, note_out, busy, done, position);
         end
      end
      step();
      vectors++;
      if ({note_out, busy, done} !== {4'd0, 1'b1, 1'b0}) begin
         miscompares++;
         $display("FAIL song1_gap: note/busy/done got %0d/%0b/%0b want 0/1/0", note_out, busy, done);
      end
      step();
      vectors++;
      if ({note_out, busy, done, position} !== {4'd0, 1'b0, 1'b1, 5'd0}) begin
         miscompares++;
         $display("FAIL song1_done: note/busy/done/pos got %0d/%0b/%0b/%0d want 0/0/1/0", note_out, busy, done, position);
      end
      step();
      vectors++;
      if (done !== 1'b0) begin
         miscompares++;
         $display("FAIL done_width: done got %0b want 0", done);
      end
      song_select = 2'd0;
   endtask

   task automatic test_stop_and_reset();
      song_select = 2'd0;
      start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 1; i < 4; i++) step();
      vectors++;
      if ({note_out, busy} !== {4'd1, 1'b1}) begin
         miscompares++;
         $display("FAIL stop_pre: note/busy got %0d/%0b want 1/1", note_out, busy);
      end
      stop = 1'b1;
      start = 1'b1;
      song_select = 2'd1;
      step();
      stop = 1'b0;
      start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         vectors++;
         if ({note_out, busy, done, position} !== 11'd0) begin
            miscompares++;
            $display("FAIL stop_start %0d: note/busy/done/pos got %0d/%0b/%0b/%0d want 0/0/0/0", i, note_out, busy, done, position);
         end
         step();
      end
      song_select = 2'd0;
      start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 1; i < 16; i++) step();
      vectors++;
      if ({note_out, busy, position} !== {4'd0, 1'b1, 5'd1}) begin
         miscompares++;
         $display("FAIL gap_pre: note/busy/pos got %0d/%0b/%0d want 0/1/1", note_out, busy, position);
      end
      rst = 1'b1;
      step();
      rst = 1'b0;
      vectors++;
      if ({note_out, busy, done, position} !== 11'd0) begin
         miscompares++;
         $display("FAIL gap_reset: note/busy/done/pos got %0d/%0b/%0b/%0d want 0/0/0/0", note_out, busy, done, position);
      end
      step();
      vectors++;
      if ({note_out, busy, done, position} !== 11'd0) begin
         miscompares++;
         $display("FAIL post_reset: note/busy/done/pos got %0d/%0b/%0b/%0d want 0/0/0/0", note_out, busy, done, position);
      end
   endtask

   initial begin
      test_reset();
      test_one_shot();
      test_loop();
      test_pause();
      test_select();
      test_stop_and_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
